axi_mem_read: RTL and testbench

AXI4 read-channel responder for the on-chip byte-addressed memory; the read counterpart of the memory write responder. It accepts one AR request at a time and walks FIXED/INCR (optionally WRAP) bursts, issuing one full-width memory read per beat. Each beat is returned on the R channel with RRESP/RLAST, and R backpressure is honoured. It sits between the AXI slave interface and the memory read port.

---
 rtl/axi_pkg.sv | 40 ++++
 rtl/axi_mem_read_if.sv | 37 +++
 rtl/axi_burst_addr.sv | 46 ++++
 rtl/axi_mem_read.sv | 156 +++++++++++++++
 tb/tb_axi_mem_read.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Brief    : Shared AXI burst/response types, read-FSM states, LEN helper.
// Revision : 1.0
// ============================================================================
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_WAIT  = 2'd2,
        RD_RESP  = 2'd3
    } rd_state_e;

    function automatic int unsigned len_log2(input int unsigned len_bytes);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < len_bytes) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_read_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_mem_read_if
// Brief    : AXI4 AR/R channel bundle with master and slave views.
// Revision : 1.0
// ============================================================================
interface axi_mem_read_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_burst_addr
// Brief    : Combinational next-beat address and end-of-memory overflow flag.
// Revision : 1.0
// ============================================================================
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN    = 8
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        burst_i,
    input  logic [7:0]        wrap_len_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              ovf_o
);
    localparam int LOG2LEN = len_log2(LEN);

    logic [ADDR_W:0]   w_incr;
    logic [ADDR_W:0]   w_span;
    logic [ADDR_W-1:0] w_wrap_mask;

    assign w_incr      = {1'b0, addr_i} + (ADDR_W+1)'(LEN);
    // A span equal to the whole memory truncates to 0 and the mask becomes all ones.
    assign w_span      = ((ADDR_W+1)'(wrap_len_i) + (ADDR_W+1)'(1)) << LOG2LEN;
    assign w_wrap_mask = w_span[ADDR_W-1:0] - ADDR_W'(1);

    always_comb begin
        next_addr_o = addr_i;
        ovf_o       = 1'b0;
        case (burst_i)
            BURST_INCR: begin
                next_addr_o = w_incr[ADDR_W-1:0];
                ovf_o       = w_incr[ADDR_W];
            end
            BURST_WRAP: begin
                next_addr_o = (addr_i & ~w_wrap_mask) | (w_incr[ADDR_W-1:0] & w_wrap_mask);
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/axi_mem_read.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_mem_read
// Brief    : AXI4 read responder for the byte-addressed on-chip memory.
//            Define AXI_RD_WRAP_EN to accept WRAP bursts.
// Revision : 1.0
// ============================================================================
module axi_mem_read
    import axi_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_mem_read_if.slave     axi,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int LEN     = DATA_W / 8;
    localparam int LOG2LEN = len_log2(LEN);

    localparam logic [1:0] S_IDLE  = RD_IDLE;
    localparam logic [1:0] S_FETCH = RD_FETCH;
    localparam logic [1:0] S_WAIT  = RD_WAIT;
    localparam logic [1:0] S_RESP  = RD_RESP;

    logic [1:0]        state_q, state_d;
    logic              arready_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        cnt_q;
    logic [7:0]        wlen_q;
    logic [1:0]        burst_q;
    logic              berr_q;
    logic              perr_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;

    logic              w_ar_hs;
    logic              w_ar_err;
    logic              w_burst_bad;
    logic              w_beat_err;
    logic [ADDR_W-1:0] w_next;
    logic              w_ovf;

    assign w_ar_hs    = axi.ARVALID && arready_q && (state_q == S_IDLE);
    assign w_beat_err = berr_q || perr_q;

    always_comb begin
        w_burst_bad = 1'b1;
        case (axi.ARBURST)
            BURST_FIXED, BURST_INCR: w_burst_bad = 1'b0;
`ifdef AXI_RD_WRAP_EN
            BURST_WRAP: w_burst_bad = !(axi.ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
            BURST_WRAP: w_burst_bad = 1'b1;
`endif
            default:    w_burst_bad = 1'b1;
        endcase
    end

    assign w_ar_err = (axi.ARSIZE != 3'(LOG2LEN)) || w_burst_bad;

    axi_burst_addr #(
        .ADDR_W (ADDR_W),
        .LEN    (LEN)
    ) u_burst_addr (
        .addr_i      (addr_q),
        .burst_i     (burst_q),
        .wrap_len_i  (wlen_q),
        .next_addr_o (w_next),
        .ovf_o       (w_ovf)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_ar_hs) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP:  if (axi.RREADY) state_d = (cnt_q == 8'd0) ? S_IDLE : S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            arready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            wlen_q    <= '0;
            burst_q   <= '0;
            berr_q    <= 1'b0;
            perr_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (w_ar_hs) begin
                        arready_q <= 1'b0;
                        id_q      <= axi.ARID;
                        addr_q    <= axi.ARADDR & ~ADDR_W'(LEN - 1);
                        cnt_q     <= axi.ARLEN;
                        wlen_q    <= axi.ARLEN;
                        burst_q   <= axi.ARBURST;
                        berr_q    <= w_ar_err;
                        perr_q    <= 1'b0;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= w_beat_err ? '0 : mem_rdata;
                    rresp_q  <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_q  <= (cnt_q == 8'd0);
                end
                S_RESP: begin
                    if (axi.RREADY) begin
                        rvalid_q <= 1'b0;
                        if (cnt_q != 8'd0) begin
                            cnt_q <= cnt_q - 8'd1;
                            // Past the top of memory the address freezes and the rest of the burst errors.
                            if (w_ovf) perr_q <= 1'b1;
                            else       addr_q <= w_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_en   = (state_q == S_FETCH) && !w_beat_err;
    assign mem_raddr   = addr_q;

    assign axi.ARREADY = arready_q;
    assign axi.RID     = id_q;
    assign axi.RDATA   = rdata_q;
    assign axi.RRESP   = rresp_q;
    assign axi.RLAST   = rlast_q;
    assign axi.RVALID  = rvalid_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_mem_read.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_read
// Brief    : Directed bench for axi_mem_read with a burst-level reference model.
// Revision : 1.0
// ============================================================================
module tb_axi_mem_read;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata = '0;

    axi_mem_read_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

    axi_mem_read #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .axi       (axi),
        .mem_rd_en (mem_rd_en),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    logic [7:0] mem [0:4095];

    function automatic logic [63:0] word_at(input int a);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = mem[(a + b) & 4095];
        return w;
    endfunction

    always @(posedge ACLK) if (mem_rd_en) mem_rdata <= word_at(int'(mem_raddr));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // Reference model: expected R beats and expected memory read addresses.
    logic [63:0] q_data [$];
    logic [1:0]  q_resp [$];
    logic        q_last [$];
    logic [3:0]  q_id   [$];
    int          q_raddr[$];

    task automatic expect_burst(input int addr, input int len, input int size, input int burst, input int id);
        int a, span, boundary, ai;
        bit whole, ovf, err;
        a = addr & ~7;
        span = 8 * (len + 1);
        whole = (size != 3) || (burst == 3);
        if (burst == 2) begin
`ifdef AXI_RD_WRAP_EN
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) whole = 1;
`else
            whole = 1;
`endif
        end
        boundary = a - (a % span);
        ovf = 0;
        for (int i = 0; i <= len; i++) begin
            case (burst)
                1:       ai = a + 8 * i;
                2:       ai = boundary + ((a - boundary + 8 * i) % span);
                default: ai = a;
            endcase
            if (burst == 1 && ai > 4095) ovf = 1;
            err = whole || ovf;
            q_data.push_back(err ? 64'd0 : word_at(ai));
            q_resp.push_back(err ? 2'b10 : 2'b00);
            q_last.push_back(i == len);
            q_id.push_back(4'(id));
            if (!err) q_raddr.push_back(ai);
        end
    endtask

    task automatic flush_model();
        q_data.delete(); q_resp.delete(); q_last.delete(); q_id.delete(); q_raddr.delete();
    endtask

    // Observation log used by the literal checks.
    int          beats_seen = 0;
    logic [63:0] last_data;
    logic [3:0]  last_id;
    logic [1:0]  obs_resp [$];
    logic        obs_last [$];
    int          obs_raddr[$];
    logic        stalled = 1'b0;

    task automatic clear_obs();
        obs_resp.delete(); obs_last.delete(); obs_raddr.delete();
    endtask

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            stalled = 1'b0;
        end else begin
            if (axi.RVALID) begin
                if (q_data.size() == 0) begin
                    fail_now("unexpected_r_beat");
                end else begin
                    check("rdata", axi.RDATA, q_data[0]);
                    check("rresp", 64'(axi.RRESP), 64'(q_resp[0]));
                    check("rlast", 64'(axi.RLAST), 64'(q_last[0]));
                    check("rid",   64'(axi.RID),   64'(q_id[0]));
                    if (axi.RREADY) begin
                        last_data = axi.RDATA;
                        last_id   = axi.RID;
                        obs_resp.push_back(axi.RRESP);
                        obs_last.push_back(axi.RLAST);
                        void'(q_data.pop_front()); void'(q_resp.pop_front());
                        void'(q_last.pop_front()); void'(q_id.pop_front());
                        beats_seen++;
                    end
                end
                stalled = !axi.RREADY;
            end else if (stalled) begin
                fail_now("rvalid_dropped_without_handshake");
                stalled = 1'b0;
            end
            if (mem_rd_en) begin
                obs_raddr.push_back(int'(mem_raddr));
                if (q_raddr.size() == 0) fail_now("unexpected_mem_read");
                else check("mem_raddr", 64'(mem_raddr), 64'(q_raddr.pop_front()));
            end
        end
    end

    task automatic ar(input int addr, input int len, input int size, input int burst, input int id);
        bit done;
        done = 0;
        axi.ARADDR  = 12'(addr);
        axi.ARLEN   = 8'(len);
        axi.ARSIZE  = 3'(size);
        axi.ARBURST = 2'(burst);
        axi.ARID    = 4'(id);
        axi.ARVALID = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge ACLK);
            if (axi.ARREADY) begin
                expect_burst(addr, len, size, burst, id);
                @(posedge ACLK); #1;
                axi.ARVALID = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            axi.ARVALID = 1'b0;
            fail_now("ar_handshake_timeout");
        end
    endtask

    task automatic wait_done();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge ACLK); #1;
            if (q_data.size() == 0 && !axi.RVALID) done = 1;
        end
        if (!done) fail_now("burst_timeout");
        check("reads_outstanding", 64'(q_raddr.size()), 64'd0);
    endtask

    task automatic wait_beats(input int target);
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge ACLK); #1;
            if (beats_seen >= target) done = 1;
        end
        if (!done) fail_now("beat_wait_timeout");
    endtask

    task automatic wait_rvalid();
        bit done;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge ACLK); #1;
            if (axi.RVALID) done = 1;
        end
        if (!done) fail_now("rvalid_wait_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 7 + 3) & 255);
        for (int i = 0; i < 8; i++) mem[16 + i] = 8'(i + 1);
        axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0;
        axi.ARBURST = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b1;

        repeat (3) @(posedge ACLK);
        #1;
        check("reset_arready", 64'(axi.ARREADY), 64'd0);
        check("reset_rvalid",  64'(axi.RVALID),  64'd0);
        check("reset_rlast",   64'(axi.RLAST),   64'd0);
        check("reset_rresp",   64'(axi.RRESP),   64'd0);
        check("reset_rdata",   axi.RDATA,        64'd0);
        check("reset_rid",     64'(axi.RID),     64'd0);
        check("reset_rd_en",   64'(mem_rd_en),   64'd0);
        check("reset_raddr",   64'(mem_raddr),   64'd0);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check("arready_after_reset", 64'(axi.ARREADY), 64'd1);

        // Single INCR beat with latency pinning.
        clear_obs();
        ar(16, 0, 3, 1, 3);
        check("t1_rd_en_after_hs",   64'(mem_rd_en),  64'd1);
        check("t1_raddr",            64'(mem_raddr),  64'h010);
        check("t1_rvalid_n1",        64'(axi.RVALID), 64'd0);
        @(posedge ACLK); #1;
        check("t1_rvalid_n1b",       64'(axi.RVALID), 64'd0);
        @(posedge ACLK); #1;
        check("t1_rvalid_n2",        64'(axi.RVALID), 64'd1);
        wait_done();
        check("t1_rdata_literal", last_data, 64'h0807060504030201);
        check("t1_rlast_literal", 64'(obs_last[0]), 64'd1);
        @(posedge ACLK); #1;
        check("t1_arready_back", 64'(axi.ARREADY), 64'd1);

        // INCR x4 with a 5-cycle stall on beat 1.
        clear_obs();
        base = beats_seen;
        ar(256, 3, 3, 1, 7);
        wait_beats(base + 1);
        axi.RREADY = 1'b0;
        wait_rvalid();
        repeat (5) @(posedge ACLK);
        #1;
        axi.RREADY = 1'b1;
        wait_done();
        check("t2_nreads", 64'(obs_raddr.size()), 64'd4);
        check("t2_a0", 64'(obs_raddr[0]), 64'h100);
        check("t2_a1", 64'(obs_raddr[1]), 64'h108);
        check("t2_a2", 64'(obs_raddr[2]), 64'h110);
        check("t2_a3", 64'(obs_raddr[3]), 64'h118);
        check("t2_last2", 64'(obs_last[2]), 64'd0);
        check("t2_last3", 64'(obs_last[3]), 64'd1);

        // INCR running off the top of memory.
        clear_obs();
        ar(12'hFF0, 3, 3, 1, 1);
        wait_done();
        check("t3_resp0", 64'(obs_resp[0]), 64'd0);
        check("t3_resp1", 64'(obs_resp[1]), 64'd0);
        check("t3_resp2", 64'(obs_resp[2]), 64'd2);
        check("t3_resp3", 64'(obs_resp[3]), 64'd2);
        check("t3_nreads", 64'(obs_raddr.size()), 64'd2);
        check("t3_lastdata", last_data, 64'd0);

        // Wrong ARSIZE: whole burst errors.
        clear_obs();
        ar(64, 3, 2, 1, 2);
        wait_done();
        check("t4_nbeats", 64'(obs_resp.size()), 64'd4);
        check("t4_resp3", 64'(obs_resp[3]), 64'd2);
        check("t4_last2", 64'(obs_last[2]), 64'd0);
        check("t4_last3", 64'(obs_last[3]), 64'd1);
        check("t4_nreads", 64'(obs_raddr.size()), 64'd0);

        // WRAP burst.
        clear_obs();
        ar(12'h118, 3, 3, 2, 4);
        wait_done();
`ifdef AXI_RD_WRAP_EN
        check("t5_a0", 64'(obs_raddr[0]), 64'h118);
        check("t5_a1", 64'(obs_raddr[1]), 64'h100);
        check("t5_a2", 64'(obs_raddr[2]), 64'h108);
        check("t5_a3", 64'(obs_raddr[3]), 64'h110);
`else
        check("t5_nreads", 64'(obs_raddr.size()), 64'd0);
        check("t5_resp0", 64'(obs_resp[0]), 64'd2);
        check("t5_resp3", 64'(obs_resp[3]), 64'd2);
`endif

        // FIXED from an unaligned address.
        clear_obs();
        ar(12'h20B, 2, 3, 0, 6);
        wait_done();
        check("t6_nreads", 64'(obs_raddr.size()), 64'd3);
        check("t6_a2", 64'(obs_raddr[2]), 64'h208);

        // Reserved burst type.
        clear_obs();
        ar(128, 1, 3, 3, 9);
        wait_done();
        check("t7_nreads", 64'(obs_raddr.size()), 64'd0);
        check("t7_resp1", 64'(obs_resp[1]), 64'd2);

        // Reset in the middle of an 8-beat burst.
        clear_obs();
        base = beats_seen;
        ar(12'h300, 7, 3, 1, 10);
        wait_beats(base + 2);
        axi.RREADY = 1'b0;
        wait_rvalid();
        ARESETn = 1'b0;
        flush_model();
        @(posedge ACLK); #1;
        check("t8_rvalid_in_reset",  64'(axi.RVALID),  64'd0);
        check("t8_arready_in_reset", 64'(axi.ARREADY), 64'd0);
        ARESETn = 1'b1;
        axi.RREADY = 1'b1;
        @(posedge ACLK); #1;
        check("t8_arready_after_release", 64'(axi.ARREADY), 64'd1);
        ar(32, 0, 3, 1, 5);
        wait_done();
        check("t8_rid_literal", 64'(last_id), 64'd5);
        check("t8_beats_after_reset", 64'(beats_seen), 64'(base + 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
